// File: rtl/landing_gear_pkg.sv
// Shared definitions for the landing-gear controller: state encoding and per-state outputs.
package landing_gear_pkg;

    localparam int unsigned STATE_W = 3;

    // State encoding (legacy-compatible 3-bit constants)
    localparam logic [STATE_W-1:0] TAXI  = 3'd0;
    localparam logic [STATE_W-1:0] TUP   = 3'd1;
    localparam logic [STATE_W-1:0] TDN   = 3'd2;
    localparam logic [STATE_W-1:0] GOUP  = 3'd3;
    localparam logic [STATE_W-1:0] FLYUP = 3'd4;
    localparam logic [STATE_W-1:0] GODN  = 3'd5;
    localparam logic [STATE_W-1:0] FLYDN = 3'd6;

    // Cockpit / hydraulic output bundle, MSB first: red, grn, valve, pump, timer
    typedef struct packed {
        logic red;
        logic grn;
        logic valve;
        logic pump;
        logic timer;
    } gear_out_t;

    localparam int unsigned OUT_W = 5;

    localparam gear_out_t OUT_TAXI  = gear_out_t'(5'b01101);
    localparam gear_out_t OUT_TUP   = gear_out_t'(5'b01100);
    localparam gear_out_t OUT_TDN   = gear_out_t'(5'b01100);
    localparam gear_out_t OUT_GOUP  = gear_out_t'(5'b10011);
    localparam gear_out_t OUT_FLYUP = gear_out_t'(5'b00001);
    localparam gear_out_t OUT_GODN  = gear_out_t'(5'b10111);
    localparam gear_out_t OUT_FLYDN = gear_out_t'(5'b01101);

endpackage

// File: rtl/landing_gear_controller.sv
// Moore FSM sequencing landing-gear hydraulics, cockpit LEDs and the external takeoff timer.
module landing_gear_controller
    import landing_gear_pkg::*;
(
    input  logic Clock,
    input  logic Clear,
    input  logic GearIsDown,
    input  logic GearIsUp,
    input  logic PlaneOnGround,
    input  logic TimeUp,
    input  logic Lever,
    output logic RedLED,
    output logic GrnLED,
    output logic Valve,
    output logic Pump,
    output logic Timer
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    gear_out_t          out_q;
    gear_out_t          out_next;

    // State and output registers; outputs are registered from the next-state decode so they track the state
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state <= TAXI;
            out_q <= OUT_TAXI;
        end else begin
            state <= state_next;
            out_q <= out_next;
        end
    end

    // Next-state logic; conditions listed in priority order, holding by default
    always_comb begin
        state_next = state;
        case (state)
            TAXI: begin
                if (!PlaneOnGround) begin
                    state_next = Lever ? TDN : TUP;
                end
            end
            TUP, TDN: begin
                if (PlaneOnGround)          state_next = TAXI;
                else if (TimeUp && Lever)   state_next = FLYDN;
                else if (TimeUp)            state_next = GOUP;
                else if (Lever)             state_next = TDN;
                else                        state_next = TUP;
            end
            GOUP: begin
                // Retraction always completes before the lever is honoured
                if (GearIsUp) state_next = FLYUP;
            end
            FLYUP: begin
                if (Lever) state_next = GODN;
            end
            GODN: begin
                // Extension always completes before the lever is honoured
                if (GearIsDown && PlaneOnGround) state_next = TAXI;
                else if (GearIsDown)             state_next = FLYDN;
            end
            FLYDN: begin
                if (PlaneOnGround) state_next = TAXI;
                else if (!Lever)   state_next = GOUP;
            end
            default: state_next = TAXI;
        endcase
    end

    // Output decode of the state about to be entered
    always_comb begin
        out_next = OUT_TAXI;
        case (state_next)
            TAXI:    out_next = OUT_TAXI;
            TUP:     out_next = OUT_TUP;
            TDN:     out_next = OUT_TDN;
            GOUP:    out_next = OUT_GOUP;
            FLYUP:   out_next = OUT_FLYUP;
            GODN:    out_next = OUT_GODN;
            FLYDN:   out_next = OUT_FLYDN;
            default: out_next = OUT_TAXI;
        endcase
    end

    assign RedLED = out_q.red;
    assign GrnLED = out_q.grn;
    assign Valve  = out_q.valve;
    assign Pump   = out_q.pump;
    assign Timer  = out_q.timer;

endmodule

// File: tb/tb_landing_gear_controller.sv
// Directed table-driven bench for the landing-gear controller.
module tb_landing_gear_controller;

    // Bench-local encodings and expected output words {Red,Grn,Valve,Pump,Timer}
    localparam logic [2:0] S_TAXI  = 3'd0;
    localparam logic [2:0] S_TUP   = 3'd1;
    localparam logic [2:0] S_TDN   = 3'd2;
    localparam logic [2:0] S_GOUP  = 3'd3;
    localparam logic [2:0] S_FLYUP = 3'd4;
    localparam logic [2:0] S_GODN  = 3'd5;
    localparam logic [2:0] S_FLYDN = 3'd6;

    localparam logic [4:0] O_TAXI  = 5'b01101;
    localparam logic [4:0] O_TAIR  = 5'b01100;
    localparam logic [4:0] O_GOUP  = 5'b10011;
    localparam logic [4:0] O_FLYUP = 5'b00001;
    localparam logic [4:0] O_GODN  = 5'b10111;
    localparam logic [4:0] O_FLYDN = 5'b01101;

    typedef struct {
        logic       clr;
        logic [4:0] in;     // {Dn,Up,Gnd,TU,Lv}
        logic [2:0] st;
        logic [4:0] out;
    } vec_t;

    logic clk;
    logic clear;
    logic gear_is_down, gear_is_up, plane_on_ground, time_up, lever;
    logic red_led, grn_led, valve, pump, timer;

    int n_checks;
    int n_fail;
    vec_t vecs[$];

    landing_gear_controller dut (
        .Clock        (clk),
        .Clear        (clear),
        .GearIsDown   (gear_is_down),
        .GearIsUp     (gear_is_up),
        .PlaneOnGround(plane_on_ground),
        .TimeUp       (time_up),
        .Lever        (lever),
        .RedLED       (red_led),
        .GrnLED       (grn_led),
        .Valve        (valve),
        .Pump         (pump),
        .Timer        (timer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic c, input logic [4:0] i, input logic [2:0] s, input logic [4:0] o);
        vec_t v;
        v.clr = c;
        v.in  = i;
        v.st  = s;
        v.out = o;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic c, input logic [4:0] i);
        clear           = c;
        gear_is_down    = i[4];
        gear_is_up      = i[3];
        plane_on_ground = i[2];
        time_up         = i[1];
        lever           = i[0];
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Apply one vector at the falling edge, compare just after the next rising edge
    task automatic step(input int idx, input vec_t v);
        @(negedge clk);
        drive(v.clr, v.in);
        @(posedge clk);
        #1;
        check($sformatf("row%0d_state", idx), 5'(dut.state), 5'(v.st));
        check($sformatf("row%0d_out", idx), {red_led, grn_led, valve, pump, timer}, v.out);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        drive(1'b0, 5'b00000);

        // 1: reset and basic TAXI/TUP/TDN moves
        add(1'b1, 5'b00000, S_TAXI,  O_TAXI);
        add(1'b0, 5'b10000, S_TUP,   O_TAIR);
        add(1'b0, 5'b10000, S_TUP,   O_TAIR);
        add(1'b0, 5'b10001, S_TDN,   O_TAIR);
        add(1'b0, 5'b10000, S_TUP,   O_TAIR);
        add(1'b0, 5'b10100, S_TAXI,  O_TAXI);
        // 2: full retract/extend cycle
        add(1'b0, 5'b10000, S_TUP,   O_TAIR);
        add(1'b0, 5'b00010, S_GOUP,  O_GOUP);
        add(1'b0, 5'b01010, S_FLYUP, O_FLYUP);
        add(1'b0, 5'b00011, S_GODN,  O_GODN);
        add(1'b0, 5'b10011, S_FLYDN, O_FLYDN);
        add(1'b0, 5'b10100, S_TAXI,  O_TAXI);
        // 3: timer expiry with lever down from TUP and TDN
        add(1'b0, 5'b10000, S_TUP,   O_TAIR);
        add(1'b0, 5'b10011, S_FLYDN, O_FLYDN);
        add(1'b0, 5'b00010, S_GOUP,  O_GOUP);
        add(1'b0, 5'b01000, S_FLYUP, O_FLYUP);
        add(1'b0, 5'b00001, S_GODN,  O_GODN);
        add(1'b0, 5'b10101, S_TAXI,  O_TAXI);
        add(1'b0, 5'b10001, S_TDN,   O_TAIR);
        add(1'b0, 5'b10011, S_FLYDN, O_FLYDN);
        add(1'b0, 5'b10100, S_TAXI,  O_TAXI);
        // 4: don't-cares on the ground and landing from TUP/TDN
        add(1'b0, 5'b10101, S_TAXI,  O_TAXI);
        add(1'b0, 5'b10110, S_TAXI,  O_TAXI);
        add(1'b0, 5'b10111, S_TAXI,  O_TAXI);
        add(1'b0, 5'b10000, S_TUP,   O_TAIR);
        add(1'b0, 5'b10111, S_TAXI,  O_TAXI);
        add(1'b0, 5'b10001, S_TDN,   O_TAIR);
        add(1'b0, 5'b10110, S_TAXI,  O_TAXI);
        // 5: lever/timer/ground ignored mid-transit
        add(1'b0, 5'b10000, S_TUP,   O_TAIR);
        add(1'b0, 5'b00010, S_GOUP,  O_GOUP);
        add(1'b0, 5'b00011, S_GOUP,  O_GOUP);
        add(1'b0, 5'b00101, S_GOUP,  O_GOUP);
        add(1'b0, 5'b00000, S_GOUP,  O_GOUP);
        add(1'b0, 5'b01010, S_FLYUP, O_FLYUP);
        add(1'b0, 5'b01000, S_FLYUP, O_FLYUP);
        add(1'b0, 5'b01010, S_FLYUP, O_FLYUP);
        add(1'b0, 5'b00001, S_GODN,  O_GODN);
        add(1'b0, 5'b00010, S_GODN,  O_GODN);
        add(1'b0, 5'b00000, S_GODN,  O_GODN);
        add(1'b0, 5'b10001, S_FLYDN, O_FLYDN);
        add(1'b0, 5'b10011, S_FLYDN, O_FLYDN);
        add(1'b0, 5'b10100, S_TAXI,  O_TAXI);
        // 6: Clear overrides a retraction in progress
        add(1'b0, 5'b10000, S_TUP,   O_TAIR);
        add(1'b0, 5'b00010, S_GOUP,  O_GOUP);
        add(1'b1, 5'b01010, S_TAXI,  O_TAXI);
        // setup for illegal-state recovery: reach FLYUP
        add(1'b0, 5'b10000, S_TUP,   O_TAIR);
        add(1'b0, 5'b00010, S_GOUP,  O_GOUP);
        add(1'b0, 5'b01000, S_FLYUP, O_FLYUP);

        foreach (vecs[i]) step(i, vecs[i]);

        // Illegal encoding injected while holding in FLYUP must recover to TAXI
        @(negedge clk);
        drive(1'b0, 5'b01000);
        force dut.state = 3'b111;
        #1;
        release dut.state;
        @(posedge clk);
        #1;
        check("illegal_state", 5'(dut.state), 5'(S_TAXI));
        check("illegal_out", {red_led, grn_led, valve, pump, timer}, O_TAXI);

        // Unused encoding 7 is the only spare; also confirm the FSM keeps running afterwards
        @(negedge clk);
        drive(1'b0, 5'b10001);
        @(posedge clk);
        #1;
        check("post_recover_state", 5'(dut.state), 5'(S_TDN));
        check("post_recover_out", {red_led, grn_led, valve, pump, timer}, O_TAIR);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
